aes_inv_round_ctrl: RTL and testbench

Round sequencer for the AES inverse cipher (decryption datapath). The round counter on the encrypt side counts key indices upward from 0 to Nr. This block is its counterpart: it walks the expanded-key store downward from Nr to 0 and prefetches each round key one cycle ahead. It drives the state-register enable and the first-round/last-round qualifiers for the InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns datapath. It sits between the key-expansion unit (key store, 1-cycle read latency) and the decryption round datapath.

---
 rtl/aes_inv_round_ctrl.sv | 86 ++++++++
 tb/tb_aes_inv_round_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl: AES inverse-cipher round sequencer.
// Walks the key store from NR down to 0. Each round key is prefetched one cycle ahead.
// Ports:
//   clk, reset (sync, active-high)
//   start, key_ready          block request / key store valid
//   in_ready, busy            IDLE / not IDLE
//   key_rd_en, key_rd_addr    key store read (1-cycle latency)
//   round_idx                 key index presented to the datapath
//   first_round, last_round   datapath round qualifiers
//   state_en, done            state register load / plaintext valid pulse
module aes_inv_round_ctrl #(
    parameter int NR = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_ready,
    output logic       in_ready,
    output logic       busy,
    output logic       key_rd_en,
    output logic [3:0] key_rd_addr,
    output logic [3:0] round_idx,
    output logic       first_round,
    output logic       last_round,
    output logic       state_en,
    output logic       done
);
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR4 = 4'(NR);

    typedef enum logic [2:0] {IDLE, WAIT_KEY, PREFETCH, ROUND, DONE} state_t;

    state_t     state, state_nx;
    logic [3:0] idx_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            round_idx <= '0;
        end else begin
            state     <= state_nx;
            round_idx <= idx_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = round_idx;
        key_rd_en   = 1'b0;
        key_rd_addr = '0;
        first_round = 1'b0;
        last_round  = 1'b0;
        state_en    = 1'b0;
        in_ready    = state == IDLE;
        busy        = state != IDLE;
        done        = state == DONE;
        case (state)
            IDLE:     if (start) state_nx = key_ready ? PREFETCH : WAIT_KEY;
            WAIT_KEY: if (key_ready) state_nx = PREFETCH;
            PREFETCH: begin
                key_rd_en   = 1'b1;
                key_rd_addr = NR4;
                idx_nx      = NR4;
                state_nx    = ROUND;
            end
            ROUND: begin
                state_en    = 1'b1;
                first_round = round_idx == NR4;
                last_round  = round_idx == 4'd0;
                // Prefetch the next key; at index 0 hold the counter so it never wraps.
                if (round_idx != 4'd0) begin
                    key_rd_en   = 1'b1;
                    key_rd_addr = round_idx - 4'd1;
                    idx_nx      = round_idx - 4'd1;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// tb_aes_inv_round_ctrl: directed checks of the inverse round sequencer for NR=10/12/14.
module tb_aes_inv_round_ctrl;
    logic clk, reset, start, key_ready;
    logic       ir_v[3], bz_v[3], en_v[3], fr_v[3], lr_v[3], se_v[3], dn_v[3];
    logic [3:0] addr_v[3], idx_v[3];
    int n_chk = 0, n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_inv_round_ctrl #(.NR(10 + 2 * g)) dut (
            .clk(clk), .reset(reset), .start(start), .key_ready(key_ready),
            .in_ready(ir_v[g]), .busy(bz_v[g]), .key_rd_en(en_v[g]),
            .key_rd_addr(addr_v[g]), .round_idx(idx_v[g]),
            .first_round(fr_v[g]), .last_round(lr_v[g]),
            .state_en(se_v[g]), .done(dn_v[g])
        );
    end

    // Key store model: returns the requested key index one cycle after the read.
    logic       kv;
    logic [3:0] ka;
    always @(posedge clk) begin
        kv <= en_v[1];
        ka <= addr_v[1];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int st, kr, ir, bz, en, addr, idx, fr, lr, se, dn;
    } vec_t;
    vec_t tv[18];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] obs(int k);
        return {ir_v[k], bz_v[k], en_v[k], addr_v[k], idx_v[k], fr_v[k], lr_v[k], se_v[k], dn_v[k]};
    endfunction

    function automatic logic [14:0] expv(vec_t v);
        return {1'(v.ir), 1'(v.bz), 1'(v.en), 4'(v.addr), 4'(v.idx), 1'(v.fr), 1'(v.lr), 1'(v.se), 1'(v.dn)};
    endfunction

    int n, dn, t10, t14, f10, f14, cnt;
    int dt[4];

    initial begin
        //          st kr ir bz en addr idx fr lr se dn
        tv[0]  = '{1, 1, 0, 1, 1, 12,  0, 0, 0, 0, 0};
        tv[1]  = '{0, 1, 0, 1, 1, 11, 12, 1, 0, 1, 0};
        tv[2]  = '{0, 1, 0, 1, 1, 10, 11, 0, 0, 1, 0};
        tv[3]  = '{0, 1, 0, 1, 1,  9, 10, 0, 0, 1, 0};
        tv[4]  = '{0, 1, 0, 1, 1,  8,  9, 0, 0, 1, 0};
        tv[5]  = '{0, 1, 0, 1, 1,  7,  8, 0, 0, 1, 0};
        tv[6]  = '{0, 1, 0, 1, 1,  6,  7, 0, 0, 1, 0};
        tv[7]  = '{0, 1, 0, 1, 1,  5,  6, 0, 0, 1, 0};
        tv[8]  = '{0, 1, 0, 1, 1,  4,  5, 0, 0, 1, 0};
        tv[9]  = '{0, 1, 0, 1, 1,  3,  4, 0, 0, 1, 0};
        tv[10] = '{0, 1, 0, 1, 1,  2,  3, 0, 0, 1, 0};
        tv[11] = '{0, 1, 0, 1, 1,  1,  2, 0, 0, 1, 0};
        tv[12] = '{0, 1, 0, 1, 1,  0,  1, 0, 0, 1, 0};
        tv[13] = '{0, 1, 0, 1, 0,  0,  0, 0, 1, 1, 0};
        tv[14] = '{0, 1, 0, 1, 0,  0,  0, 0, 0, 0, 1};
        tv[15] = '{0, 1, 1, 0, 0,  0,  0, 0, 0, 0, 0};
        tv[16] = '{0, 1, 1, 0, 0,  0,  0, 0, 0, 0, 0};
        tv[17] = '{0, 1, 1, 0, 0,  0,  0, 0, 0, 0, 0};

        reset = 1'b1; start = 1'b0; key_ready = 1'b0;
        step();
        for (int k = 0; k < 3; k++) chk($sformatf("reset_nr%0d", 10 + 2 * k), int'(obs(k)), 32'h4000);
        reset = 1'b0;
        step();

        // Nominal block: NR=12 against the table; NR=10/14 timed alongside.
        t10 = -1; t14 = -1; f10 = -1; f14 = -1;
        for (int i = 0; i < 18; i++) begin
            start = 1'(tv[i].st);
            key_ready = 1'(tv[i].kr);
            step();
            chk($sformatf("vec%0d", i), int'(obs(1)), int'(expv(tv[i])));
            if (tv[i].se != 0) chk($sformatf("key_align%0d", i), int'({kv, ka}), int'({1'b1, 4'(tv[i].idx)}));
            if (dn_v[0] && t10 < 0) t10 = i + 1;
            if (dn_v[2] && t14 < 0) t14 = i + 1;
            if (fr_v[0]) f10 = int'(idx_v[0]);
            if (fr_v[2]) f14 = int'(idx_v[2]);
        end
        chk("nr10_done_cycle", t10, 13);
        chk("nr14_done_cycle", t14, 17);
        chk("nr10_first_idx", f10, 10);
        chk("nr14_first_idx", f14, 14);

        // Start while the key store is not ready.
        key_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wait_key%0d", i), int'({ir_v[1], bz_v[1], en_v[1], se_v[1]}), 4'b0100);
            if (i < 4) step();
        end
        key_ready = 1'b1;
        n = 0;
        do begin step(); n++; end while (!dn_v[1] && n < 40);
        chk("wait_done_latency", n, 15);
        step();

        // Reset in the middle of the rounds, with start asserted alongside.
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (idx_v[1] != 4'd6 && n < 40) begin step(); n++; end
        chk("reach_idx6", int'(idx_v[1]), 6);
        reset = 1'b1; start = 1'b1;
        step();
        chk("mid_reset", int'(obs(1)), 32'h4000);
        reset = 1'b0; start = 1'b0;
        dn = 0;
        repeat (20) begin step(); dn += int'(dn_v[1]); end
        chk("no_done_after_reset", dn, 0);
        chk("idle_after_reset", int'(ir_v[1]), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!dn_v[1] && n < 40) begin step(); n++; end
        chk("restart_latency", n, 15);
        step();

        // Start pulsed during ROUND is ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        dn = 0;
        repeat (30) begin step(); dn += int'(dn_v[1]); end
        chk("start_in_round_done_count", dn, 1);

        // Start held high: one block every NR+4 cycles.
        start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (dn_v[1] && cnt < 4) begin dt[cnt] = i; cnt++; end
        end
        start = 1'b0;
        chk("held_done_count", cnt, 3);
        chk("held_first_done", dt[0], 14);
        chk("held_interval0", dt[1] - dt[0], 16);
        chk("held_interval1", dt[2] - dt[1], 16);
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
